aud_dac_player: RTL and testbench

- I2S playback stage for the WM8731 codec. Runs downstream of the codec-configuration block and is enabled by that block's finished flag.
- Accepts stereo sample frames through a valid/ready handshake and serialises them MSB-first on DACDAT.
- Frame timing comes from the codec-mastered DACLRCK; the codec is configured as master, I2S format, 16-bit.
- Holds one frame of buffering and counts underruns.

---
 rtl/aud_dac_player.sv | 144 ++++++++++++++
 tb/tb_aud_dac_player.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aud_dac_player.sv
// I2S playback stage for a codec-mastered WM8731 link: one-frame holding buffer, MSB-first serialiser, underrun counter.
// Build option: AUD_DAC_HOLD_LAST_EN replays the last played frame on underrun instead of silence.
module aud_dac_player #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned UCNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic [UCNT_W-1:0] o_underrun_cnt
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_L, S_LEFT, S_RIGHT} state_t;

  state_t            state;
  logic              lrck_r;
  logic              fall;
  logic              rise;
  logic              accept;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic [DATA_W-1:0] win_l;
  logic [DATA_W-1:0] win_r;
  logic [DATA_W-1:0] load_l;
  logic [DATA_W-1:0] load_r;
  logic [CNT_W-1:0]  cnt;

  assign fall    = lrck_r & ~i_daclrck;
  assign rise    = ~lrck_r & i_daclrck;
  assign o_ready = i_en && !hold_full && (state != S_IDLE);
  assign accept  = i_valid && o_ready;

  // Shift registers stay intact while playing; the current bit is the MSB of a shifted view.
  always_comb begin
    win_l = sh_l << cnt;
    win_r = sh_r << cnt;
  end

  always_comb begin
    if (hold_full) begin
      load_l = hold_l;
      load_r = hold_r;
    end else begin
`ifdef AUD_DAC_HOLD_LAST_EN
      load_l = sh_l;
      load_r = sh_r;
`else
      load_l = '0;
      load_r = '0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      lrck_r         <= 1'b0;
      hold_full      <= 1'b0;
      hold_l         <= '0;
      hold_r         <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      cnt            <= '0;
      o_aud_dacdat   <= 1'b0;
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      lrck_r     <= i_daclrck;
      o_underrun <= 1'b0;
      if (!i_en) begin
        state        <= S_IDLE;
        o_aud_dacdat <= 1'b0;
        hold_full    <= 1'b0;
        hold_l       <= '0;
        hold_r       <= '0;
        cnt          <= '0;
      end else begin
        // Acceptance and a frame load never both touch hold_full: ready is low while full.
        if (accept) begin
          hold_l    <= i_left;
          hold_r    <= i_right;
          hold_full <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            o_aud_dacdat <= 1'b0;
            cnt          <= '0;
            state        <= S_WAIT_L;
          end
          S_WAIT_L, S_RIGHT: begin
            if (fall) begin
              sh_l         <= load_l;
              sh_r         <= load_r;
              o_aud_dacdat <= load_l[DATA_W-1];
              cnt          <= CNT_ONE;
              state        <= S_LEFT;
              if (hold_full) begin
                hold_full <= 1'b0;
              end else begin
                o_underrun <= 1'b1;
                if (o_underrun_cnt != '1) o_underrun_cnt <= o_underrun_cnt + 1'b1;
              end
            end else if (state == S_WAIT_L) begin
              o_aud_dacdat <= 1'b0;
            end else if (cnt < CNT_MAX) begin
              o_aud_dacdat <= win_r[DATA_W-1];
              cnt          <= cnt + 1'b1;
            end else begin
              o_aud_dacdat <= 1'b0;
            end
          end
          S_LEFT: begin
            if (rise) begin
              o_aud_dacdat <= sh_r[DATA_W-1];
              cnt          <= CNT_ONE;
              state        <= S_RIGHT;
            end else if (cnt < CNT_MAX) begin
              o_aud_dacdat <= win_l[DATA_W-1];
              cnt          <= cnt + 1'b1;
            end else begin
              o_aud_dacdat <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_dac_player.sv
// Scoreboard bench for aud_dac_player: a frame-level model predicts each played frame; a monitor deserialises DACDAT.
module tb_aud_dac_player;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic        i_daclrck;
  logic        i_valid;
  logic [15:0] i_left;
  logic [15:0] i_right;
  logic        o_ready;
  logic        o_aud_dacdat;
  logic        o_underrun;
  logic [15:0] o_underrun_cnt;
  logic        s_ready;
  logic        s_dacdat;
  logic        s_underrun;
  logic [1:0]  s_cnt;

  always #5 i_clk = ~i_clk;

  aud_dac_player #(.DATA_W(16), .UCNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_daclrck(i_daclrck),
    .i_left(i_left), .i_right(i_right), .i_valid(i_valid),
    .o_ready(o_ready), .o_aud_dacdat(o_aud_dacdat), .o_underrun(o_underrun),
    .o_underrun_cnt(o_underrun_cnt)
  );

  // Second instance never receives frames: every frame underruns, exercising a 2-bit counter.
  aud_dac_player #(.DATA_W(16), .UCNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_daclrck(i_daclrck),
    .i_left(16'h0000), .i_right(16'h0000), .i_valid(1'b0),
    .o_ready(s_ready), .o_aud_dacdat(s_dacdat), .o_underrun(s_underrun),
    .o_underrun_cnt(s_cnt)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        und;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int unsigned start;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          mon_busy = 0;

  // Frame-level reference state
  bit          active, slot_full, lrck_q, sb_on, acc;
  logic [15:0] slot_l, slot_r, last_l, last_r, ucnt;
  logic [1:0]  ucnt2;
  int          nfall, ph;

  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One BCLK: drive at the falling edge, then advance the model over the next rising edge.
  task automatic step(input logic en, input logic v, input logic [15:0] l, input logic [15:0] r);
    logic fall, mr;
    exp_t e;
    @(negedge i_clk);
    i_en = en; i_valid = v; i_left = l; i_right = r;
    ph = (ph + 1) % 64;
    i_daclrck = (ph >= 32);
    fall = lrck_q && !i_daclrck;
    lrck_q = i_daclrck;
    #1;
    mr = en && active && !slot_full;
    chk("ready", 32'(o_ready), 32'(mr));
    acc = 0;
    if (!en) begin
      active = 0;
      slot_full = 0;
    end else if (!active) begin
      active = 1;
    end else begin
      if (fall) begin
        if (slot_full) begin
          e.l = slot_l; e.r = slot_r; e.und = 0;
          slot_full = 0;
        end else begin
          e.und = 1;
          if (ucnt != 16'hFFFF) ucnt = ucnt + 16'd1;
`ifdef AUD_DAC_HOLD_LAST_EN
          e.l = last_l; e.r = last_r;
`else
          e.l = 16'h0000; e.r = 16'h0000;
`endif
        end
        ucnt2 = (ucnt2 == 2'd3) ? 2'd3 : ucnt2 + 2'd1;
        last_l = e.l; last_r = e.r;
        e.cnt = ucnt; e.cnt2 = ucnt2;
        e.start = cyc + 1;
        if (sb_on) q.push_back(e);
        nfall++;
      end
      if (v && mr) begin
        slot_l = l; slot_r = r; slot_full = 1; acc = 1;
      end
    end
  endtask

  // Monitor: reassemble each 64-BCLK frame from DACDAT and compare against the queued prediction.
  initial begin : monitor
    exp_t        cur;
    int unsigned k;
    logic [15:0] gl, gr;
    bit          padbad;
    forever begin
      @(posedge i_clk); #1;
      if (!mon_busy && q.size() > 0) begin
        if (q[0].start == cyc) begin
          cur = q.pop_front();
          mon_busy = 1; gl = '0; gr = '0; padbad = 0;
          chk("underrun_pulse", 32'(o_underrun), 32'(cur.und));
          chk("underrun_cnt", 32'(o_underrun_cnt), 32'(cur.cnt));
          chk("sat_cnt", 32'(s_cnt), 32'(cur.cnt2));
        end else if (q[0].start < cyc) begin
          chk("frame_start", cyc, q[0].start);
          void'(q.pop_front());
        end
      end
      if (mon_busy) begin
        k = cyc - cur.start;
        if (k == 1) chk("underrun_width", 32'(o_underrun), 32'd0);
        if (k < 16) gl = {gl[14:0], o_aud_dacdat};
        else if (k >= 32 && k < 48) gr = {gr[14:0], o_aud_dacdat};
        else if (o_aud_dacdat !== 1'b0) padbad = 1;
        if (k == 63) begin
          chk("left_word", 32'(gl), 32'(cur.l));
          chk("right_word", 32'(gr), 32'(cur.r));
          chk("zero_pad", 32'(padbad), 32'd0);
          mon_busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [15:0] n;
    int          g, nf;
    bit          quiet_bad;
    active = 0; slot_full = 0; sb_on = 1; acc = 0;
    slot_l = '0; slot_r = '0; last_l = '0; last_r = '0; ucnt = '0; ucnt2 = '0;
    nfall = 0; ph = 32; n = 16'd1;
    i_rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_left = '0; i_right = '0; i_daclrck = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_dacdat", 32'(o_aud_dacdat), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_underrun", 32'(o_underrun), 32'd0);
    chk("rst_cnt", 32'(o_underrun_cnt), 32'd0);
    chk("rst_sat_cnt", 32'(s_cnt), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    lrck_q = i_daclrck;

    g = 0;
    while (nfall < 32 && g < 3000) begin
      g++;
      if (nfall == 0) step(1, 1, 16'hA5C3, 16'h0F01);
      else if (nfall <= 8) begin
        step(1, 1, n, ~n);
        if (acc) n = n + 16'd1;
      end else if (nfall <= 12) begin
        if (nfall == 12 && ph == 63) step(1, 1, 16'h5AA5, 16'hC33C);
        else step(1, 0, 16'h0000, 16'h0000);
      end else begin
        step(1, ($urandom_range(0, 3) != 0) && ($urandom_range(0, 15) == 0),
             16'($urandom), 16'($urandom));
      end
    end
    if (nfall < 32) chk("frame_progress", 32'(nfall), 32'd32);
    sb_on = 0;
    repeat (70) step(1, 0, 16'h0000, 16'h0000);
    chk("scoreboard_drain", {31'(q.size()), mon_busy}, 32'd0);

    // Enable drop mid-left, re-enable mid-right.
    nf = nfall; g = 0;
    while (nfall == nf && g < 200) begin step(1, 1, 16'hFFFF, 16'hFFFF); g++; end
    g = 0;
    while (ph != 8 && g < 100) begin step(1, 0, 16'h0000, 16'h0000); g++; end
    chk("pre_disable_dat", 32'(o_aud_dacdat), 32'd1);
    step(0, 0, 16'h0000, 16'h0000);
    @(posedge i_clk); #1;
    chk("disable_dat", 32'(o_aud_dacdat), 32'd0);
    chk("disable_ready", 32'(o_ready), 32'd0);
    g = 0;
    while (ph != 40 && g < 100) begin step(0, 0, 16'h0000, 16'h0000); g++; end
    nf = nfall; quiet_bad = 0; g = 0;
    while (g < 100) begin
      step(1, 0, 16'h0000, 16'h0000);
      if (o_aud_dacdat !== 1'b0) quiet_bad = 1;
      if (nfall != nf) break;
      g++;
    end
    chk("reenable_quiet", 32'(quiet_bad), 32'd0);
    chk("reenable_fall_seen", 32'(nfall - nf), 32'd1);

    // Asynchronous reset in the middle of a full-scale frame.
    nf = nfall; g = 0;
    while (nfall == nf && g < 200) begin step(1, 1, 16'hFFFF, 16'hFFFF); g++; end
    repeat (3) step(1, 0, 16'h0000, 16'h0000);
    chk("pre_reset_dat", 32'(o_aud_dacdat), 32'd1);
    chk("pre_reset_cnt", 32'(o_underrun_cnt), 32'(ucnt));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_dacdat", 32'(o_aud_dacdat), 32'd0);
    chk("async_ready", 32'(o_ready), 32'd0);
    chk("async_underrun", 32'(o_underrun), 32'd0);
    chk("async_cnt", 32'(o_underrun_cnt), 32'd0);
    chk("async_sat_cnt", 32'(s_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
